// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the iteration-counter width helper.
package seq_restoring_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Counter must hold 0..WIDTH, hence clog2(WIDTH+1).
    function automatic int counter_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

endpackage

// File: rtl/seq_restoring_divider_ripple_borrow_subtractor.sv
// Combinational ripple-borrow subtractor: diff = a - b, borrow_out set when
// b > a. A chain of full-subtractor cells with the first borrow-in tied low.
module ripple_borrow_subtractor #(
    parameter int N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    logic [N:0] borrow_s;

    assign borrow_s[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        // Full-subtractor cell: difference bit and borrow to the next stage.
        assign diff[i]       = a[i] ^ b[i] ^ borrow_s[i];
        assign borrow_s[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow_s[i]);
    end

    assign borrow_out = borrow_s[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider. One quotient bit is resolved per
// clock in RUN; divide-by-zero short-circuits straight to DONE.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = counter_width(WIDTH);

    div_state_t       state_r;
    div_state_t       state_next_s;

    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [CNT_W-1:0] cnt_r;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             dbz_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             borrow_s;
    logic [WIDTH:0]   rem_step_s;
    logic [WIDTH-1:0] q_step_s;
    logic             last_iter_s;
    logic             accept_s;
    logic             divisor_zero_s;

    assign shifted_s      = {rem_r[WIDTH-1:0], q_r[WIDTH-1]};
    assign last_iter_s    = (cnt_r == CNT_W'(WIDTH - 1));
    assign divisor_zero_s = (divisor == {WIDTH{1'b0}});
    assign accept_s       = (state_r == ST_IDLE) && start;

    // Width is WIDTH+1 so the shifted partial remainder never overflows.
    ripple_borrow_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .a          (shifted_s),
        .b          ({1'b0, dvsr_r}),
        .diff       (trial_s),
        .borrow_out (borrow_s)
    );

    // One restoring step: keep the trial difference unless it borrowed.
    always_comb begin
        rem_step_s = shifted_s;
        q_step_s   = {q_r[WIDTH-2:0], 1'b0};
        if (!borrow_s) begin
            rem_step_s = trial_s;
            q_step_s   = {q_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_step_s = shifted_s;
            q_step_s   = {q_r[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state decode for the IDLE/RUN/DONE controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (divisor_zero_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_iter_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Working remainder, quotient shift register, latched divisor and counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r  <= {(WIDTH+1){1'b0}};
            q_r    <= {WIDTH{1'b0}};
            dvsr_r <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !divisor_zero_s) begin
                        rem_r  <= {(WIDTH+1){1'b0}};
                        q_r    <= dividend;
                        dvsr_r <= divisor;
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    rem_r <= rem_step_s;
                    q_r   <= q_step_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Result registers change only when entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            dbz_r       <= 1'b0;
        end else if (accept_s && divisor_zero_s) begin
            quotient_r  <= {WIDTH{1'b1}};
            remainder_r <= dividend;
            dbz_r       <= 1'b1;
        end else if ((state_r == ST_RUN) && last_iter_s) begin
            quotient_r  <= q_step_s;
            remainder_r <= rem_step_s[WIDTH-1:0];
            dbz_r       <= 1'b0;
        end
    end

    // busy/done registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule
